// File: rtl/spi_sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_sram_arb_pkg
// Description : Shared types and widths for the two-port SPI SRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_sram_arb_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 8;

    // Arbiter FSM states: waiting for a request, or serving port 0 / port 1
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    // Requester identifier
    typedef logic port_t;

    localparam port_t PORT0 = 1'b0;
    localparam port_t PORT1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/spi_sram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : spi_sram_arb_pick
// Description : Combinational winner selection for the two-port arbiter.
//               Rules in order: single requester, starvation bound, lock of
//               the previous holder, then fixed or round-robin tie-break.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sram_arb_pick
    import spi_sram_arb_pkg::*;
#(
    parameter bit          PRIO_PORT0 = 1'b1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic       i_req0,
    input  logic       i_req1,
    input  port_t      i_last_grant,
    input  logic       i_lock_flag,
    input  logic [3:0] i_starve_cnt,
    output port_t      o_winner
);

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    // Priority-ordered selection; the result is only meaningful when a request is present
    always_comb begin
        o_winner = PORT0;
        if (i_req0 && !i_req1) begin
            o_winner = PORT0;
        end else if (i_req1 && !i_req0) begin
            o_winner = PORT1;
        end else if (i_starve_cnt == c_starve_max) begin
            // Both requesting and the last holder used up its run: hand over
            o_winner = ~i_last_grant;
        end else if (i_lock_flag) begin
            o_winner = i_last_grant;
        end else if (PRIO_PORT0) begin
            o_winner = PORT0;
        end else begin
            o_winner = ~i_last_grant;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_sram_arbiter
// Description : Shares one spi_sram_master memory port between the CPU
//               (port 0) and a secondary requester (port 1). Holds the
//               IDLE/BUSY FSM, starvation counter, lock flag and muxing.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sram_arbiter
    import spi_sram_arb_pkg::*;
#(
    parameter bit          PRIO_PORT0 = 1'b1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              ready
);

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    state_t            r_state;
    state_t            w_state_next;
    port_t             r_last_grant;
    logic              r_lock_flag;
    logic [3:0]        r_starve_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_wr;
    logic [DATA_W-1:0] r_mem_wdata;
    port_t             w_winner;
    logic              w_grant;
    logic              w_other_req;

    spi_sram_arb_pick #(
        .PRIO_PORT0 (PRIO_PORT0),
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .i_req0       (req0),
        .i_req1       (req1),
        .i_last_grant (r_last_grant),
        .i_lock_flag  (r_lock_flag),
        .i_starve_cnt (r_starve_cnt),
        .o_winner     (w_winner)
    );

    // The loser of the current grant: is it also waiting?
    assign w_other_req = (w_winner == PORT1) ? req0 : req1;

    // Memory request fields are captured at grant so they stay frozen through BUSY
    assign mem_en    = (r_state != IDLE);
    assign mem_addr  = r_mem_addr;
    assign mem_wr    = r_mem_wr;
    assign mem_wdata = r_mem_wdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, grant strobe and the unregistered completion path
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        ack0         = 1'b0;
        ack1         = 1'b0;
        rdata        = '0;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_grant      = 1'b1;
                    w_state_next = (w_winner == PORT1) ? BUSY1 : BUSY0;
                end
            end
            BUSY0: begin
                if (ready) begin
                    // A reset in the same cycle aborts the access without an ack
                    ack0         = ~rst;
                    rdata        = rst ? '0 : mem_rdata;
                    w_state_next = IDLE;
                end
            end
            BUSY1: begin
                if (ready) begin
                    ack1         = ~rst;
                    rdata        = rst ? '0 : mem_rdata;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Grant bookkeeping: last holder, lock, starvation run length and captured request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= PORT1;
            r_lock_flag  <= 1'b0;
            r_starve_cnt <= 4'd0;
            r_mem_addr   <= '0;
            r_mem_wr     <= 1'b0;
            r_mem_wdata  <= '0;
        end else if (w_grant) begin
            r_last_grant <= w_winner;
            r_lock_flag  <= (w_winner == PORT1) ? lock1 : lock0;
            if ((w_winner == r_last_grant) && w_other_req) begin
                r_starve_cnt <= (r_starve_cnt == c_starve_max) ? r_starve_cnt
                                                               : r_starve_cnt + 4'd1;
            end else begin
                r_starve_cnt <= 4'd1;
            end
            r_mem_addr  <= (w_winner == PORT1) ? addr1  : addr0;
            r_mem_wr    <= (w_winner == PORT1) ? wr1    : wr0;
            r_mem_wdata <= (w_winner == PORT1) ? wdata1 : wdata0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_sram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_sram_arbiter
// Description : Scoreboard bench for spi_sram_arbiter: directed scenarios and
//               random two-port traffic against a rule-level reference model,
//               plus a round-robin instance driven with continuous requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_sram_arbiter;

    localparam int STARVE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance (port 0 priority)
    logic        req0 = 0, req1 = 0, lock0 = 0, lock1 = 0, wr0 = 0, wr1 = 0;
    logic [23:0] addr0 = '0, addr1 = '0;
    logic [7:0]  wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, mem_en, mem_wr;
    logic [7:0]  rdata, mem_wdata;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic        ready = 1'b0;

    spi_sram_arbiter #(.PRIO_PORT0(1'b1), .STARVE_MAX(STARVE)) u_dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wr0(wr0), .wr1(wr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .mem_addr(mem_addr), .mem_en(mem_en),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .ready(ready)
    );

    // Round-robin instance
    logic        rr_req0 = 0, rr_req1 = 0, rr_ready = 0;
    logic        rr_ack0, rr_ack1, rr_mem_en, rr_mem_wr;
    logic [7:0]  rr_rdata, rr_mem_wdata;
    logic [23:0] rr_mem_addr;

    spi_sram_arbiter #(.PRIO_PORT0(1'b0), .STARVE_MAX(4)) u_rr (
        .clk(clk), .rst(rst), .req0(rr_req0), .req1(rr_req1), .lock0(1'b0), .lock1(1'b0),
        .addr0(24'h000010), .addr1(24'h800020), .wr0(1'b0), .wr1(1'b0),
        .wdata0(8'h00), .wdata1(8'h00),
        .ack0(rr_ack0), .ack1(rr_ack1), .rdata(rr_rdata), .mem_addr(rr_mem_addr),
        .mem_en(rr_mem_en), .mem_wr(rr_mem_wr), .mem_wdata(rr_mem_wdata),
        .mem_rdata(8'h5A), .ready(rr_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    typedef struct {
        int          port;
        logic [23:0] addr;
        logic        wr;
        logic [7:0]  wdata;
        longint      cyc;
    } grant_t;

    grant_t exp_grant[$];
    int     exp_ack[$];
    int     ack_log[$];
    longint cyc = 0;
    bit     mon_on = 0;
    logic [7:0] last_rdata = '0;
    bit     s_hold = 0, s_force = 0, s_spur = 0;
    logic [7:0] s_force_val = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: applies the arbitration rules once per cycle and
    // predicts each grant (contents and cycle) and the port of its ack
    initial begin
        int     m_last, m_cnt, w;
        bit     m_lock, m_busy, other;
        grant_t g;
        m_last = 1; m_cnt = 0; m_lock = 0; m_busy = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_last = 1; m_cnt = 0; m_lock = 0; m_busy = 0;
                exp_grant.delete();
                exp_ack.delete();
            end else if (m_busy) begin
                if (ready) m_busy = 0;
            end else if (req0 || req1) begin
                if (req0 && !req1)           w = 0;
                else if (req1 && !req0)      w = 1;
                else if (m_cnt == STARVE)    w = 1 - m_last;
                else if (m_lock)             w = m_last;
                else                         w = 0;
                other = (w == 0) ? req1 : req0;
                if (w == m_last && other) m_cnt = (m_cnt < STARVE) ? m_cnt + 1 : m_cnt;
                else                      m_cnt = 1;
                m_last  = w;
                m_lock  = (w == 0) ? lock0 : lock1;
                g.port  = w;
                g.addr  = (w == 0) ? addr0 : addr1;
                g.wr    = (w == 0) ? wr0 : wr1;
                g.wdata = (w == 0) ? wdata0 : wdata1;
                g.cyc   = cyc + 1;
                exp_grant.push_back(g);
                exp_ack.push_back(w);
                m_busy = 1;
            end
        end
    end

    // Monitor: compares every session start, busy cycle and ack with the model
    initial begin
        bit     prev_en;
        bit     have_cur;
        grant_t cur;
        int     p;
        prev_en = 0; have_cur = 0;
        forever begin
            @(negedge clk);
            if (!mon_on) begin
                prev_en = 0;
            end else if (rst) begin
                chk(!(ack0 || ack1), "ack_during_reset", {ack1, ack0}, 0);
                have_cur = 0;
                prev_en  = mem_en;
            end else begin
                if (mem_en && !prev_en) begin
                    if (exp_grant.size() == 0) begin
                        chk(0, "unexpected_grant", mem_addr, 0);
                        have_cur = 0;
                    end else begin
                        cur = exp_grant.pop_front();
                        have_cur = 1;
                        chk(cyc == cur.cyc, "grant_cycle", cyc, cur.cyc);
                        chk({mem_wr, mem_addr, mem_wdata} === {cur.wr, cur.addr, cur.wdata},
                            "grant_fields", {mem_wr, mem_addr, mem_wdata}, {cur.wr, cur.addr, cur.wdata});
                    end
                end else if (mem_en && have_cur) begin
                    chk({mem_wr, mem_addr, mem_wdata} === {cur.wr, cur.addr, cur.wdata},
                        "busy_stable", {mem_wr, mem_addr, mem_wdata}, {cur.wr, cur.addr, cur.wdata});
                end
                if (ack0 || ack1) begin
                    if (exp_ack.size() == 0) begin
                        chk(0, "unexpected_ack", {ack1, ack0}, 0);
                    end else begin
                        p = exp_ack.pop_front();
                        chk({ready, ack1, ack0} === {1'b1, p == 1, p == 0}, "ack_port",
                            {ready, ack1, ack0}, {1'b1, p == 1, p == 0});
                        chk(rdata === mem_rdata, "ack_rdata", rdata, mem_rdata);
                    end
                    last_rdata = rdata;
                    ack_log.push_back(ack1 ? 1 : 0);
                end else if (mem_en && ready) begin
                    chk(0, "missing_ack", {ack1, ack0}, 1);
                end
                prev_en = mem_en;
            end
        end
    end

    // Memory slave: random completion latency, optional stray ready while idle
    initial begin
        int cnt;
        bit in_sess;
        cnt = 0; in_sess = 0;
        forever begin
            @(posedge clk);
            #1;
            ready = 1'b0;
            if (!mem_en) begin
                in_sess = 0;
                if (s_spur && $urandom_range(0, 3) == 0) begin
                    ready     = 1'b1;
                    mem_rdata = 8'($urandom);
                end
            end else begin
                if (!in_sess) begin
                    in_sess = 1;
                    cnt = $urandom_range(0, 3);
                end
                if (!s_hold) begin
                    if (cnt == 0) begin
                        ready     = 1'b1;
                        mem_rdata = s_force ? s_force_val : 8'($urandom);
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // Round-robin instance slave: completes one cycle into each session
    initial forever begin
        @(posedge clk);
        #1;
        rr_ready = rr_mem_en && !rr_ready;
    end

    task automatic drive(input int p, input logic r, input logic [23:0] a, input logic w,
                         input logic [7:0] d, input logic lk);
        if (p == 0) begin
            req0 = r; addr0 = a; wr0 = w; wdata0 = d; lock0 = lk;
        end else begin
            req1 = r; addr1 = a; wr1 = w; wdata1 = d; lock1 = lk;
        end
    endtask

    // One access; called just after a rising edge. keep=1 leaves req high for a follow-on
    task automatic access(input int p, input logic [23:0] a, input logic w, input logic [7:0] d,
                          input logic lk, input bit keep);
        int n;
        bit got;
        drive(p, 1'b1, a, w, d, lk);
        n = 0;
        got = 0;
        while (!got && n < 300) begin
            @(negedge clk);
            got = (p == 0) ? ack0 : ack1;
            n++;
        end
        if (!got) chk(0, "ack_timeout", p, 1);
        @(posedge clk);
        #1;
        if (!keep) drive(p, 1'b0, a, w, d, 1'b0);
    endtask

    task automatic rand_port(input int p, input int n);
        logic [23:0] a;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            a = 24'($urandom);
            a[23] = p[0];
            access(p, a, 1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), 0);
        end
    endtask

    function automatic logic [7:0] log_bits(input int base, input int n);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            if (base + i < ack_log.size()) v = {v[6:0], ack_log[base + i][0]};
            else                           v = {v[6:0], 1'b1};
        end
        return v;
    endfunction

    int base;
    int got_rr[$];
    int lows;
    bit prev_rr;
    bit seen;
    logic [23:0] la;

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(mem_en == 1'b0,     "rst_mem_en",    mem_en, 0);
        chk(ack0 == 1'b0,       "rst_ack0",      ack0, 0);
        chk(ack1 == 1'b0,       "rst_ack1",      ack1, 0);
        chk(mem_wr == 1'b0,     "rst_mem_wr",    mem_wr, 0);
        chk(mem_addr == 24'h0,  "rst_mem_addr",  mem_addr, 0);
        chk(mem_wdata == 8'h0,  "rst_mem_wdata", mem_wdata, 0);
        chk(rdata == 8'h0,      "rst_rdata",     rdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_on = 1;

        // Single port-0 read, slave returns 0xA9
        s_force = 1; s_force_val = 8'hA9;
        base = ack_log.size();
        access(0, 24'h000400, 1'b0, 8'h00, 1'b0, 0);
        s_force = 0;
        chk(ack_log.size() == base + 1 && ack_log[base] == 0, "single_read_port", log_bits(base, 1), 0);
        chk(last_rdata == 8'hA9, "single_read_rdata", last_rdata, 8'hA9);

        // Simultaneous requests: port 0 first, then port 1
        base = ack_log.size();
        fork
            access(0, 24'h000111, 1'b1, 8'h11, 1'b0, 0);
            access(1, 24'h800222, 1'b0, 8'h00, 1'b0, 0);
        join
        chk(log_bits(base, 2) == 8'b01, "simultaneous_order", log_bits(base, 2), 8'b01);

        // Starvation: port 0 streams, port 1 waits; four port-0 grants then port 1
        base = ack_log.size();
        fork
            for (int i = 0; i < 6; i++) access(0, 24'h000300 + 24'(i), 1'b0, 8'h00, 1'b0, i < 5);
            access(1, 24'h800333, 1'b1, 8'hC3, 1'b0, 0);
        join
        chk(log_bits(base, 5) == 8'b00001, "starvation_order", log_bits(base, 5), 8'b00001);

        // Lock: port 1 locked writes of 0x55 to 0x200..0x203 while port 0 competes
        base = ack_log.size();
        fork
            for (int i = 0; i < 4; i++) access(1, 24'h000200 + 24'(i), 1'b1, 8'h55, 1'b1, i < 3);
            begin
                repeat (3) @(posedge clk);
                #1;
                access(0, 24'h000444, 1'b0, 8'h00, 1'b0, 0);
            end
        join
        chk(log_bits(base, 5) == 8'b11110, "lock_order", log_bits(base, 5), 8'b11110);

        // Reset in the middle of a port-0 access
        s_hold = 1;
        drive(0, 1'b1, 24'h123456, 1'b0, 8'h00, 1'b0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = mem_en;
        end
        chk(seen, "rst_busy_entered", seen, 1);
        @(posedge clk);
        #1;
        base = ack_log.size();
        rst = 1'b1;
        drive(0, 1'b0, 24'h123456, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(mem_en == 1'b0, "rst_busy_mem_en", mem_en, 0);
        chk(ack_log.size() == base, "rst_busy_no_ack", ack_log.size() - base, 0);
        s_hold = 0;
        @(posedge clk);
        #1;
        access(0, 24'h000777, 1'b1, 8'h3C, 1'b0, 0);
        chk(ack_log.size() == base + 1 && ack_log[base] == 0, "post_reset_access", log_bits(base, 1), 0);

        // Random traffic on both ports
        s_spur = 1;
        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join
        s_spur = 0;
        repeat (3) @(negedge clk);
        chk(exp_grant.size() == 0 && exp_ack.size() == 0, "queues_drained",
            exp_grant.size() + exp_ack.size(), 0);

        // Round-robin instance: continuous requests alternate 0,1,0,1 with one idle cycle each
        @(posedge clk);
        #1;
        rr_req0 = 1; rr_req1 = 1;
        lows = 0; prev_rr = 0;
        for (int c = 0; c < 80 && got_rr.size() < 6; c++) begin
            @(negedge clk);
            if (rr_mem_en && !prev_rr) chk(lows == 1, "rr_bubble", lows, 1);
            if (!rr_mem_en) lows++;
            else            lows = 0;
            if (rr_ack0 || rr_ack1) got_rr.push_back(rr_ack1 ? 1 : 0);
            prev_rr = rr_mem_en;
        end
        @(posedge clk);
        #1;
        rr_req0 = 0; rr_req1 = 0;
        chk(got_rr.size() == 6, "rr_count", got_rr.size(), 6);
        for (int i = 0; i < got_rr.size(); i++) chk(got_rr[i] == (i % 2), "rr_order", got_rr[i], i % 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit
    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/spi_sram_arbiter.md
# spi_sram_arbiter

Two-port arbiter sharing one `spi_sram_master` memory port between the 6502 core (port 0) and a secondary requester such as a loader/DMA engine (port 1). Sits between the requesters and the master's `mem_*`/`ready` interface, selects one requester per access, forwards its address and data, and routes completion and read data back. Supports strict or round-robin priority, a starvation bound, and a lock for back-to-back sequential accesses.

## Interface
- `PRIO_PORT0`, default 1: 1 = port 0 wins ties; 0 = round-robin on ties.
- `STARVE_MAX`, default 4: maximum consecutive grants to one port while the other port is requesting, range 1..15.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `req0`/`req1` in 1: access request, held high until the matching ack.
- `lock0`/`lock1` in 1: sampled at grant; requests that this port keep priority for its next access.
- `addr0`/`addr1` in 24: byte address, held stable while the request is high.
- `wr0`/`wr1` in 1: 1 = write, 0 = read.
- `wdata0`/`wdata1` in 8: write data.
- `ack0`/`ack1` out 1: one-cycle completion pulse.
- `rdata` out 8: read data, valid in the ack cycle.
- `mem_addr` out 24, `mem_en` out 1, `mem_wr` out 1, `mem_wdata` out 8: to the master.
- `mem_rdata` in 8, `ready` in 1: from the master.
- `ready` is high for one cycle when the access on `mem_*` completes.

## Operation
- States are IDLE, BUSY0 and BUSY1.
- **IDLE:**
  - If no request is present, stay in IDLE.
  - Otherwise pick the winner and move to BUSY0 or BUSY1 on the next edge.
- **Pick rules, evaluated in this order:**
  1. Only one port requesting: that port wins.
  2. Starvation: if `starve_cnt == STARVE_MAX` and the other port is requesting, the other port wins.
  3. Lock: if the previous holder had its lock flag set, the previous holder wins.
  4. Tie with `PRIO_PORT0 = 1`: port 0 wins.
  5. Tie with `PRIO_PORT0 = 0`: the port not granted last wins.
- **BUSY*n*:**
  - `mem_en = 1`.
  - `mem_addr`, `mem_wr` and `mem_wdata` are muxed from port *n*.
  - On `ready`: `ack`*n* = 1, `rdata = mem_rdata` combinationally, return to IDLE.
- **`starve_cnt` (4 bits):**
  - Updates at grant.
  - Same port as the last grant and the other port requesting: increment, saturating at `STARVE_MAX`.
  - Otherwise: reset to 1.
- **Lock flag:**
  - Latched from `lock`*n* at grant.
  - Cleared when the other port wins.
- **Request handling:**
  - A request must stay high until its ack; dropping it early is a protocol violation, and the access still completes.
  - A request still high in its ack cycle is not rearbitrated in that cycle.
- `ready` outside BUSY is ignored.

## Timing
- Reset values: state IDLE, all outputs 0 (`mem_en`, `ack0`, `ack1`, `mem_wr`, `mem_addr`, `mem_wdata`, `rdata`), `starve_cnt = 0`, lock flag 0, last-grant = port 1 (so round-robin starts with port 0).
- Latency: a request seen in IDLE at cycle *t* gives `mem_en` high at *t+1*.
- The ack is in the same cycle as `ready`; there is no registered delay on the return path.
- After each completion there is exactly one IDLE bubble, so the minimum spacing between `mem_en` sessions is one low cycle.
- `mem_*` outputs stay stable for the whole of BUSY.
- Reset asserted mid-BUSY: the next cycle is IDLE with `mem_en = 0` and no ack is issued. The master shares `rst`, so the SPI transfer aborts cleanly.
- Simultaneous `req0`/`req1` arrival is resolved only by the pick rules, never by arrival order.

## Structure
- Package `spi_sram_arb_pkg`: `state_t` enum (IDLE, BUSY0, BUSY1), `port_t` (1 bit), `ADDR_W = 24`, `DATA_W = 8`.
- Sub-module `spi_sram_arb_pick`, combinational winner selection.
  - Inputs: reqs, last grant, lock flag, `starve_cnt`.
  - Output: winner.
  - Can be unit-tested on its own.
- The top level holds the FSM, counters and output muxing.

## Test plan
- **Single port 0 read:** `addr0 = 0x000400` with a slave model returning `0xA9` → `mem_en` one cycle after `req0`, `mem_addr = 0x000400`, `ack0` and `rdata = 0xA9` in the `ready` cycle, `ack1` never asserted.
- **Simultaneous requests, `PRIO_PORT0 = 1`:** `req0`/`req1` high in the same cycle → port 0 is served first, port 1 second after one IDLE bubble.
- **Starvation, `STARVE_MAX = 4`:** port 0 re-requests continuously while port 1 holds its request → port 0 gets exactly 4 grants, then port 1 is granted.
- **Lock:** port 1 writes `0x55` to addresses `0x000200..0x000203` with `lock1 = 1` while `req0` toggles → four consecutive port-1 grants, then port 0 is granted once the starvation bound or lock release allows.
- **Round-robin, `PRIO_PORT0 = 0`:** both ports request continuously → grants alternate 0, 1, 0, 1, each preceded by one IDLE cycle.
- **Reset mid-BUSY:** `rst` pulsed while `mem_en = 1` → next cycle `mem_en = 0`, no ack pulse, and a fresh `req0` then completes normally.
